// File: rtl/glm_share_compress.sv
// glm_share_compress
// Collects 16 beats of masked domain outputs. Each beat is registered as-is
// (glitch barrier) and XOR-compressed on the following cycle into one nibble
// of each output share. After 16 nibbles the block presents a full 64-bit
// two-share word until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready never depends on in_valid, and out_valid never depends on
// out_ready. Once out_valid is raised it stays high, with stable data, until
// it is taken.
module glm_share_compress (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] dom_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_sh0,
  output logic [63:0]  out_sh1
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [4:0]     count_q, count_d;
  logic [3:0]     wptr_q, wptr_d;
  logic [127:0]   dom_q, dom_d;
  logic           v1_q, v1_d;
  logic [63:0]    sh0_q, sh0_d;
  logic [63:0]    sh1_q, sh1_d;
  logic [3:0]     nib_s, nib_t;
  logic           accept;

  // Ready is held low while reset is asserted, and whenever the frame is
  // complete or waiting to be taken.
  assign in_ready  = rst_n && (state_q == COLLECT) && (count_q < 5'd16);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == FULL);
  assign out_sh0   = sh0_q;
  assign out_sh1   = sh1_q;

  // XOR the s and t fields of all 16 domains, using only the registered copy
  always_comb begin
    nib_s = 4'h0;
    nib_t = 4'h0;
    for (int d = 0; d < 16; d++) begin
      nib_s = nib_s ^ dom_q[8*d +: 4];
      nib_t = nib_t ^ dom_q[8*d+4 +: 4];
    end
  end

  // Next-state logic: capture, write the compressed nibble, frame sequencing
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    dom_d   = dom_q;
    v1_d    = 1'b0;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;

    if (accept) begin
      dom_d   = dom_in;
      v1_d    = 1'b1;
      count_d = count_q + 5'd1;
    end

    if (v1_q) begin
      sh0_d[{wptr_q, 2'b00} +: 4] = nib_s;
      sh1_d[{wptr_q, 2'b00} +: 4] = nib_t;
      wptr_d = wptr_q + 4'd1;
      if (wptr_q == 4'd15) begin
        state_d = FULL;
      end
    end

    // The handshake cycle never accepts a beat because in_ready is low in FULL
    if ((state_q == FULL) && out_ready) begin
      state_d = COLLECT;
      count_d = 5'd0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      count_q <= 5'd0;
      wptr_q  <= 4'd0;
      dom_q   <= 128'd0;
      v1_q    <= 1'b0;
      sh0_q   <= 64'd0;
      sh1_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      dom_q   <= dom_d;
      v1_q    <= v1_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
    end
  end

endmodule
